// File: rtl/dice_roll_animator_pkg.sv
// Shared types and constants for the dice roll display animator.
package dice_roll_animator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    FLASH = 2'd2,
    SHOW  = 2'd3
  } state_e;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] CHASE_0 = 7'(1 << SEG_A);
  localparam logic [6:0] CHASE_1 = 7'(1 << SEG_B);
  localparam logic [6:0] CHASE_2 = 7'(1 << SEG_C);
  localparam logic [6:0] CHASE_3 = 7'(1 << SEG_D);
  localparam logic [6:0] CHASE_4 = 7'(1 << SEG_E);
  localparam logic [6:0] CHASE_5 = 7'(1 << SEG_F);

  localparam logic [2:0] CHASE_LAST = 3'd5;

  // Counter width that stays at least one bit wide for degenerate parameters.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [6:0] chase_pattern(input logic [2:0] pos);
    case (pos)
      3'd0:    return CHASE_0;
      3'd1:    return CHASE_1;
      3'd2:    return CHASE_2;
      3'd3:    return CHASE_3;
      3'd4:    return CHASE_4;
      3'd5:    return CHASE_5;
      default: return CHASE_0;
    endcase
  endfunction

endpackage

// File: rtl/dice_roll_animator_seg7.sv
// Hex digit to 7-segment decoder, active-high, bit0=a .. bit6=g.
module dice_roll_animator_seg7
  import dice_roll_animator_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_c_o
);

  always_comb begin
    seg_c_o = 7'h00;
    case (digit_i)
      4'h0: seg_c_o = 7'h3F;
      4'h1: seg_c_o = 7'h06;
      4'h2: seg_c_o = 7'h5B;
      4'h3: seg_c_o = 7'h4F;
      4'h4: seg_c_o = 7'h66;
      4'h5: seg_c_o = 7'h6D;
      4'h6: seg_c_o = 7'h7D;
      4'h7: seg_c_o = 7'h07;
      4'h8: seg_c_o = 7'h7F;
      4'h9: seg_c_o = 7'h6F;
      4'hA: seg_c_o = 7'h77;
      4'hB: seg_c_o = 7'h7C;
      4'hC: seg_c_o = 7'h39;
      4'hD: seg_c_o = 7'h5E;
      4'hE: seg_c_o = 7'h79;
      4'hF: seg_c_o = 7'h71;
      default: seg_c_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/dice_roll_animator.sv
// Rolling chase, flashing reveal and steady display of a latched digit.
module dice_roll_animator
  import dice_roll_animator_pkg::*;
#(
  parameter int unsigned STEP_TICKS  = 50,
  parameter int unsigned ROLL_STEPS  = 12,
  parameter int unsigned FLASH_TICKS = 100,
  parameter int unsigned FLASH_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic [6:0] segments,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned TICK_W  = cnt_width((STEP_TICKS > FLASH_TICKS) ? STEP_TICKS : FLASH_TICKS);
  localparam int unsigned STEP_W  = cnt_width(ROLL_STEPS);
  localparam int unsigned FCNT_W  = cnt_width(FLASH_COUNT + 1);
  localparam logic [TICK_W-1:0] STEP_END  = TICK_W'(STEP_TICKS - 1);
  localparam logic [TICK_W-1:0] FLASH_END = TICK_W'(FLASH_TICKS - 1);
  localparam logic [STEP_W-1:0] ROLL_END  = STEP_W'(ROLL_STEPS - 1);
  localparam logic [FCNT_W-1:0] FCNT_END  = FCNT_W'(FLASH_COUNT - 1);

  state_e            state_q, state_d;
  logic [3:0]        target_q, target_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        chase_q, chase_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              phase_off_q, phase_off_d;
  logic [6:0]        segments_d;
  logic              dp_d, busy_d;
  logic [6:0]        seg_target_c;

  // Decoding the next target lets the output register present the new digit
  // on the same edge the state enters FLASH or SHOW.
  dice_roll_animator_seg7 u_seg7 (
    .digit_i (target_d),
    .seg_c_o (seg_target_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= 4'd0;
      tick_q      <= '0;
      step_q      <= '0;
      chase_q     <= 3'd0;
      fcnt_q      <= '0;
      phase_off_q <= 1'b0;
      segments    <= 7'd0;
      dp          <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      tick_q      <= tick_d;
      step_q      <= step_d;
      chase_q     <= chase_d;
      fcnt_q      <= fcnt_d;
      phase_off_q <= phase_off_d;
      segments    <= segments_d;
      dp          <= dp_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    tick_d      = tick_q;
    step_d      = step_q;
    chase_d     = chase_q;
    fcnt_d      = fcnt_q;
    phase_off_d = phase_off_q;
    segments_d  = 7'd0;
    dp_d        = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE, SHOW: begin
        if (digit_valid) begin
          target_d = digit_in;
          state_d  = ROLL;
          tick_d   = '0;
          step_d   = '0;
          chase_d  = 3'd0;
        end
      end
      ROLL: begin
        if (digit_valid) target_d = digit_in;
        if (tick_q == STEP_END) begin
          tick_d = '0;
          if (step_q == ROLL_END) begin
            state_d     = FLASH;
            phase_off_d = 1'b0;
            fcnt_d      = '0;
          end else begin
            step_d  = step_q + 1'b1;
            chase_d = (chase_q == CHASE_LAST) ? 3'd0 : chase_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      FLASH: begin
        if (tick_q == FLASH_END) begin
          tick_d      = '0;
          phase_off_d = ~phase_off_q;
          if (phase_off_q) begin
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == FCNT_END) state_d = SHOW;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output decode of the next registered state.
    case (state_d)
      ROLL: begin
        segments_d = chase_pattern(chase_d);
        busy_d     = 1'b1;
      end
      FLASH: begin
        segments_d = phase_off_d ? 7'd0 : seg_target_c;
        busy_d     = 1'b1;
      end
      SHOW: begin
        segments_d = seg_target_c;
        dp_d       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dice_roll_animator.md
Name: dice_roll_animator

Overview:
- Downstream display stage for the pseudo-random digit generator.
- Accepts a new 4-bit digit with a one-cycle strobe, then drives the 7-segment output in three phases: a segment-chase "rolling" animation, a flashing reveal of the digit, and a steady result with the decimal point lit.
- Sits between the generator's digit register and the pad outputs: segments drive io_out[6:0], dp drives io_out[7].

Parameters:
- STEP_TICKS, 50, clk cycles per chase step (>=1).
- ROLL_STEPS, 12, number of chase steps per roll (>=1).
- FLASH_TICKS, 100, clk cycles per flash half-phase, on or off (>=1).
- FLASH_COUNT, 3, number of on/off flash pairs before steady display (>=1).

Ports:
- clk  input  1  system clock (1 kHz on the tile).
- reset  input  1  synchronous, active-high.
- digit_in  input  4  digit value from generator.
- digit_valid  input  1  one-cycle strobe; digit_in is valid this cycle.
- segments  output  7  segment drive, bit0=a .. bit6=g, active-high.
- dp  output  1  decimal point; high only in SHOW.
- busy  output  1  high in ROLL and FLASH.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; target, tick, step, chase_pos, flash_cnt, phase all 0. Outputs segments=0, dp=0, busy=0. Reset wins over digit_valid in the same cycle. Reset mid-roll or mid-flash aborts immediately to IDLE.
- All outputs are decoded from registered state only; there is no combinational path from digit_in or digit_valid to any output.
- IDLE: segments=0, dp=0, busy=0.
  - digit_valid=1 at edge t: target<=digit_in; state<=ROLL; tick=0, step=0, chase_pos=0.
  - The first chase frame is visible after edge t.
- ROLL: segments = chase pattern indexed by chase_pos, one-hot over a..f: 0->7'b0000001, 1->7'b0000010, ... 5->7'b0100000; wraps 5->0. g is never lit. busy=1, dp=0.
  - Each cycle tick increments.
  - At tick==STEP_TICKS-1: tick<=0, step<=step+1, chase_pos advances.
  - At step==ROLL_STEPS-1 and tick==STEP_TICKS-1: state<=FLASH, phase=ON, flash_cnt=0, tick=0.
  - ROLL lasts exactly ROLL_STEPS*STEP_TICKS cycles.
  - digit_valid during ROLL: target<=digit_in (latest wins); timing is not restarted.
- FLASH: busy=1, dp=0. Phase ON shows seg7(target); phase OFF shows segments=0.
  - Each phase lasts FLASH_TICKS cycles, starting with ON.
  - At the end of an OFF phase, flash_cnt increments.
  - When flash_cnt reaches FLASH_COUNT (end of last OFF): state<=SHOW.
  - FLASH lasts exactly 2*FLASH_COUNT*FLASH_TICKS cycles.
  - digit_valid during FLASH is ignored; the result is committed.
- SHOW: segments=seg7(target), dp=1, busy=0; held indefinitely.
  - digit_valid in SHOW behaves exactly as in IDLE: latch target, enter ROLL next cycle.
- Width rules:
  - tick width = clog2(max(STEP_TICKS, FLASH_TICKS)).
  - step width = clog2(ROLL_STEPS).
  - flash_cnt width = clog2(FLASH_COUNT+1).
  - Counters never exceed their terminal values; no wrap-around other than chase_pos 5->0.
- Values 8..15 on digit_in are accepted and passed to seg7 unchanged.

Decomposition:
- Shared header/package holds:
  - state encoding constants IDLE=2'd0, ROLL=2'd1, FLASH=2'd2, SHOW=2'd3;
  - six chase pattern constants;
  - segment bit-order constants (a=bit0 .. g=bit6).
- Reuse the existing seg7 decoder as the single sub-module, instantiated once on target.
- The FSM, counters and output mux live in dice_roll_animator itself.

Test Plan:
- Reset, then 20 idle cycles -> segments=0, dp=0, busy=0 throughout.
- STEP_TICKS=2, ROLL_STEPS=8, FLASH_TICKS=3, FLASH_COUNT=2; pulse digit_valid with digit_in=5 -> busy rises the next cycle, and the chase sequence changes every 2 cycles: 0000001, 0000010, 0000100, 0001000, 0010000, 0100000, 0000001, 0000010.
  - After 16 ROLL cycles: seg7(5) (a,c,d,f,g lit = 7'b1101101) for 3 cycles, then 0 for 3, then 7'b1101101 for 3, then 0 for 3.
  - Then SHOW with dp=1, busy=0, segments=7'b1101101.
- Same configuration; strobe 3, then strobe 6 at ROLL cycle 5 -> total roll length is still 16 cycles and FLASH/SHOW display seg7(6); a strobe of 2 during FLASH has no effect.
- In SHOW, strobe digit_in=1 -> the next cycle shows dp=0, busy=1, segments=7'b0000001, and a new full roll/flash sequence completes to seg7(1).
- Assert reset at ROLL cycle 7, with digit_valid=1 in the same cycle -> the next cycle is IDLE: segments=0, busy=0, dp=0; a later strobe of 4 completes a full sequence to seg7(4).
- Default parameters; strobe 7 -> busy stays high exactly 600+600=1200 cycles, then SHOW holds seg7(7) with dp=1 for 5000 further cycles.
